// File: rtl/cpu_instr_feeder_if.sv
// CPU instruction interface: word/load/start out, wait/result/flags back.
// The feeder drives the master side, the cpu core the slave side.
interface cpu_instr_feeder_if;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic        cpu_w;
    logic [15:0] cpu_out;
    logic        cpu_N;
    logic        cpu_V;
    logic        cpu_Z;

    modport master (
        output cpu_in,
        output cpu_load,
        output cpu_s,
        input  cpu_w,
        input  cpu_out,
        input  cpu_N,
        input  cpu_V,
        input  cpu_Z
    );

    modport slave (
        input  cpu_in,
        input  cpu_load,
        input  cpu_s,
        output cpu_w,
        output cpu_out,
        output cpu_N,
        output cpu_V,
        output cpu_Z
    );
endinterface

// File: rtl/cpu_instr_feeder.sv
// Instruction feeder: small program RAM issued to the cpu core one word
// at a time over a load/s/w handshake. Option: CPU_FEEDER_BREAK_ON_Z_EN.
module cpu_instr_feeder #(
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    cpu_instr_feeder_if.master cpu,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] pc,
    output logic [15:0]   last_out,
    output logic [2:0]    last_flags,
    output logic          break_hit
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ASSERT_S,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE,
        FIN,
        ERR
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0]   ram [DEPTH];
    logic [AW:0]   len_q;
    logic [AW:0]   len_clamp;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_nxt;
    logic [CW-1:0] cnt_q;
    logic [15:0]   in_q;
    logic [15:0]   first_word;
    logic [15:0]   out_q;
    logic [2:0]    flags_q;
    logic          err_q;
    logic          is_last;
    logic          tmo;
    logic          brk;
    logic          waiting;
    logic          accept;
    logic          load_c;
    logic          s_c;
    logic          busy_c;
    logic          done_c;

    assign pc_nxt  = pc_q + 1'b1;
    assign is_last = ({1'b0, pc_q} == (len_q - 1'b1));
    assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
    assign accept  = (state_q == IDLE) && start;
    assign waiting = (state_q == LOAD) ||
                     (state_q == WAIT_LOW) ||
                     (state_q == WAIT_HIGH);

    assign len_clamp = (prog_len > (AW+1)'(DEPTH)) ?
                       (AW+1)'(DEPTH) : prog_len;

    // a write landing on word 0 in the start cycle must reach the cpu
    assign first_word = (prog_we && prog_addr == '0) ?
                        prog_data : ram[0];

`ifdef CPU_FEEDER_BREAK_ON_Z_EN
    assign brk = cpu.cpu_Z && !is_last;
`else
    assign brk = 1'b0;
`endif

    // program RAM: writable only while idle, never reset
    always_ff @(posedge clk) begin
        if (state_q == IDLE && prog_we) begin
            ram[prog_addr] <= prog_data;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake strobes
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        s_c     = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (prog_len != '0) ? LOAD : FIN;
                end
            end
            LOAD: begin
                busy_c = 1'b1;
                if (cpu.cpu_w) begin
                    load_c  = 1'b1;
                    state_d = ASSERT_S;
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            ASSERT_S: begin
                busy_c  = 1'b1;
                s_c     = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                busy_c = 1'b1;
                s_c    = 1'b1;
                if (!cpu.cpu_w) begin
                    state_d = WAIT_HIGH;
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            WAIT_HIGH: begin
                busy_c = 1'b1;
                if (cpu.cpu_w) begin
                    state_d = CAPTURE;
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            CAPTURE: begin
                busy_c  = 1'b1;
                state_d = (is_last || brk) ? FIN : LOAD;
            end
            FIN: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // wait-state cycle counter, restarted whenever the state changes
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!waiting || state_d != state_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // run bookkeeping: length, pc and the word on cpu_in
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q <= '0;
            pc_q  <= '0;
            in_q  <= '0;
        end else if (accept) begin
            len_q <= len_clamp;
            pc_q  <= '0;
            if (prog_len != '0) begin
                in_q <= first_word;
            end
        end else if (state_q == CAPTURE && state_d == LOAD) begin
            pc_q <= pc_nxt;
            in_q <= ram[pc_nxt];
        end
    end

    // result capture after each completed instruction
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q   <= '0;
            flags_q <= '0;
        end else if (state_q == CAPTURE) begin
            out_q   <= cpu.cpu_out;
            flags_q <= {cpu.cpu_N, cpu.cpu_V, cpu.cpu_Z};
        end
    end

    // sticky timeout error, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state_d == ERR) begin
            err_q <= 1'b1;
        end
    end

`ifdef CPU_FEEDER_BREAK_ON_Z_EN
    logic brk_q;

    // early-stop flag, held until the next accepted start
    always_ff @(posedge clk) begin
        if (!reset) begin
            brk_q <= 1'b0;
        end else if (accept) begin
            brk_q <= 1'b0;
        end else if (state_q == CAPTURE && brk) begin
            brk_q <= 1'b1;
        end
    end

    assign break_hit = brk_q;
`else
    assign break_hit = 1'b0;
`endif

    assign cpu.cpu_in   = in_q;
    assign cpu.cpu_load = load_c;
    assign cpu.cpu_s    = s_c;
    assign busy         = busy_c;
    assign done         = done_c;
    assign err          = err_q;
    assign pc           = pc_q;
    assign last_out     = out_q;
    assign last_flags   = flags_q;

endmodule

// File: tb/tb_cpu_instr_feeder.sv
// Directed bench for cpu_instr_feeder with a handshaking cpu stub.
// Stub results come from a fixed per-instruction table.
module tb_cpu_instr_feeder;

    localparam int AW  = 4;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] pc;
    logic [15:0]   last_out;
    logic [2:0]    last_flags;
    logic          break_hit;

    cpu_instr_feeder_if bus ();

    cpu_instr_feeder #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_len   (prog_len),
        .start      (start),
        .cpu        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc         (pc),
        .last_out   (last_out),
        .last_flags (last_flags),
        .break_hit  (break_hit)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cpu stub: drops w after s, raises it dly cycles later
    logic        hang = 1'b0;
    int          dly = 0;
    int          scnt;
    logic [15:0] ir;

    function automatic logic [18:0] resp(input logic [15:0] w);
        case (w)
            16'hD004: resp = {16'h0004, 3'b000};
            16'hC020: resp = {16'h0004, 3'b000};
            16'hA801: resp = {16'h0000, 3'b001};
            default:  resp = {8'h00, w[7:0], 3'b000};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            bus.cpu_w   <= 1'b1;
            bus.cpu_out <= '0;
            bus.cpu_N   <= 1'b0;
            bus.cpu_V   <= 1'b0;
            bus.cpu_Z   <= 1'b0;
            scnt        <= 0;
            ir          <= '0;
        end else begin
            if (bus.cpu_load) ir <= bus.cpu_in;
            if (bus.cpu_s && bus.cpu_w && !hang) begin
                bus.cpu_w <= 1'b0;
                scnt      <= dly;
            end else if (!bus.cpu_w) begin
                if (scnt == 0) begin
                    bus.cpu_w <= 1'b1;
                    {bus.cpu_out, bus.cpu_N, bus.cpu_V, bus.cpu_Z}
                        <= resp(ir);
                end else begin
                    scnt <= scnt - 1;
                end
            end
        end
    end

    // event monitors
    int   n_load, n_s, n_done;
    logic busy_seen;
    logic s_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.cpu_load === 1'b1) n_load++;
        if (bus.cpu_s === 1'b1 && !s_prev) n_s++;
        s_prev = (bus.cpu_s === 1'b1);
        if (done === 1'b1) n_done++;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_load    = 0;
        n_s       = 0;
        n_done    = 0;
        busy_seen = 1'b0;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic run(input int len, output int cyc);
        clr();
        prog_len = (AW+1)'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        prog_we  = 1'b0;
        cyc      = 0;
        while (!(done || err) && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("run_end", 32'(done | err), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_in"}, 32'(bus.cpu_in), 0);
        chk({tag, "_ld"}, 32'(bus.cpu_load), 0);
        chk({tag, "_s"}, 32'(bus.cpu_s), 0);
        chk({tag, "_out"}, 32'(last_out), 0);
        chk({tag, "_fl"}, 32'(last_flags), 0);
        chk({tag, "_brk"}, 32'(break_hit), 0);
    endtask

    int cyc;

    initial begin
        repeat (3) tick();
        chk_zero("rst");
        reset = 1'b1;
        tick();

        // two-instruction program, zero-delay cpu
        wr(0, 16'hD004);
        wr(1, 16'hC020);
        run(2, cyc);
        chk("t1_cyc", 32'(cyc), 10);
        tick();
        chk("t1_load", 32'(n_load), 2);
        chk("t1_s", 32'(n_s), 2);
        chk("t1_done", 32'(n_done), 1);
        chk("t1_out", 32'(last_out), 32'h4);
        chk("t1_pc", 32'(pc), 1);
        chk("t1_busy", 32'(busy), 0);

        // cmp sets Z on the last instruction
        wr(2, 16'hA801);
        run(3, cyc);
        tick();
        chk("t2_flags", 32'(last_flags), 32'b001);
        chk("t2_out", 32'(last_out), 0);
        chk("t2_pc", 32'(pc), 2);
        chk("t2_brk", 32'(break_hit), 0);

        // zero-length program
        run(0, cyc);
        chk("t3_cyc", 32'(cyc), 0);
        tick();
        chk("t3_load", 32'(n_load), 0);
        chk("t3_s", 32'(n_s), 0);
        chk("t3_done", 32'(n_done), 1);
        chk("t3_busy", 32'(busy_seen), 0);

        // cpu never drops w: timeout in the s wait
        hang = 1'b1;
        run(1, cyc);
        chk("t4_cyc", 32'(cyc), 2 + TMO);
        chk("t4_err", 32'(err), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_s", 32'(bus.cpu_s), 0);
        repeat (3) tick();
        chk("t4_sticky", 32'(err), 1);
        chk("t4_done", 32'(n_done), 0);
        hang = 1'b0;
        run(1, cyc);
        tick();
        chk("t4_clr", 32'(err), 0);
        chk("t4_done2", 32'(n_done), 1);
        chk("t4_out2", 32'(last_out), 32'h4);

        // reset while waiting for w to return
        dly      = 3;
        prog_len = 2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (4) tick();
        chk("t5_busy", 32'(busy), 1);
        chk("t5_sw", 32'({bus.cpu_s, bus.cpu_w}), 0);
        reset = 1'b0;
        tick();
        chk_zero("t5");
        reset = 1'b1;
        dly   = 0;
        tick();
        run(2, cyc);
        tick();
        chk("t5_load", 32'(n_load), 2);
        chk("t5_out", 32'(last_out), 32'h4);
        chk("t5_err", 32'(err), 0);

        // four words with Z raised by the third
        wr(3, 16'hD173);
        run(4, cyc);
        tick();
`ifdef CPU_FEEDER_BREAK_ON_Z_EN
        chk("t6_load", 32'(n_load), 3);
        chk("t6_brk", 32'(break_hit), 1);
        chk("t6_pc", 32'(pc), 2);
        chk("t6_out", 32'(last_out), 0);
`else
        chk("t6_load", 32'(n_load), 4);
        chk("t6_brk", 32'(break_hit), 0);
        chk("t6_pc", 32'(pc), 3);
        chk("t6_out", 32'(last_out), 32'h73);
`endif

        // length above DEPTH clamps to the full RAM
        for (int i = 4; i < 16; i++) wr(i, 16'hD100 | 16'(i));
        wr(15, 16'hD1AA);
        run(31, cyc);
        tick();
`ifdef CPU_FEEDER_BREAK_ON_Z_EN
        chk("t7_load", 32'(n_load), 3);
        chk("t7_pc", 32'(pc), 2);
`else
        chk("t7_load", 32'(n_load), 16);
        chk("t7_pc", 32'(pc), 15);
        chk("t7_out", 32'(last_out), 32'hAA);
`endif
        chk("t7_done", 32'(n_done), 1);

        // write to word 0 in the start cycle is used by the run
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 16'hD155;
        run(1, cyc);
        tick();
        chk("t8_load", 32'(n_load), 1);
        chk("t8_out", 32'(last_out), 32'h55);
        chk("t8_pc", 32'(pc), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, bad);
        $finish;
    end

endmodule
